qmf_analysis_tdm: RTL and testbench

Time-multiplexed, multi-channel two-band QMF analysis filter bank with built-in decimation by 2. It is the next generation of `qmf_analysis_core`: one shared serial MAC serves NCH interleaved channels, and a valid/ready input handshake replaces the free-running `en` sample stream. Each output pair (low, high) is tagged with its channel index and carries a saturation indication. It sits between the per-channel sample source and downstream sub-band processing.

---
 rtl/qmf_analysis_tdm.sv | 183 ++++++++++++++++++
 tb/tb_qmf_analysis_tdm.sv | 365 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/qmf_analysis_tdm.sv
// qmf_analysis_tdm: multi-channel two-band QMF analysis bank with decimation by 2.
// One serial MAC is shared by all channels. Each channel keeps its own delay
// line and decimation phase. Every second sample of a channel launches one MAC
// pass that produces a (low, high) output pair.
module qmf_analysis_tdm #(
  parameter int DATAW     = 16,
  parameter int COEFW     = 16,
  parameter int NTAPS     = 8,
  parameter int NCH       = 2,
  parameter int OUT_SHIFT = 15,
  parameter int CHW       = (NCH > 1) ? $clog2(NCH) : 1
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   en,
  input  logic                   s_valid,
  output logic                   s_ready,
  input  logic [CHW-1:0]         s_chan,
  input  logic [DATAW-1:0]       s_data,
  input  logic [NTAPS*COEFW-1:0] h0_coef_flat,
  output logic                   m_valid,
  output logic [CHW-1:0]         m_chan,
  output logic [DATAW-1:0]       m_low,
  output logic [DATAW-1:0]       m_high,
  output logic                   m_sat
);

  localparam int ACCW  = DATAW + COEFW + $clog2(NTAPS) + 1;
  localparam int PRODW = DATAW + COEFW;
  localparam int KW    = $clog2(NTAPS);
  localparam logic [KW-1:0]         K_LAST  = KW'(NTAPS - 1);
  localparam logic [CHW:0]          NCH_LIM = (CHW + 1)'(NCH);
  localparam logic signed [ACCW:0]  SAT_HI  = (ACCW + 1)'((64'sd1 <<< (DATAW - 1)) - 64'sd1);
  localparam logic signed [ACCW:0]  SAT_LO  = ~SAT_HI;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MAC  = 2'd1,
    ST_OUT  = 2'd2
  } state_t;

  // Floor-shift the wide result, then clamp it to the sample range; MSB flags clamping.
  function automatic logic [DATAW:0] sat_fn(input logic signed [ACCW:0] v);
    logic signed [ACCW:0] sh_s;
    logic [DATAW:0]       res_s;
    sh_s = v >>> OUT_SHIFT;
    if (sh_s > SAT_HI) begin
      res_s = {1'b1, SAT_HI[DATAW-1:0]};
    end else if (sh_s < SAT_LO) begin
      res_s = {1'b1, SAT_LO[DATAW-1:0]};
    end else begin
      res_s = {1'b0, sh_s[DATAW-1:0]};
    end
    return res_s;
  endfunction

  state_t                   state_r, state_nxt_s;
  logic                     ready_r;
  logic [NTAPS*DATAW-1:0]   dl_r [NCH];
  logic [NCH-1:0]           phase_r;
  logic [CHW-1:0]           ch_r;
  logic [KW-1:0]            k_r;
  logic signed [ACCW-1:0]   acc_e_r, acc_o_r;
  logic                     m_valid_r, m_sat_r;
  logic [CHW-1:0]           m_chan_r;
  logic [DATAW-1:0]         m_low_r, m_high_r;

  logic                     xfer_s, chan_ok_s, start_s;
  logic signed [DATAW-1:0]  tap_x_s;
  logic signed [COEFW-1:0]  tap_c_s;
  logic signed [PRODW-1:0]  prod_s;
  logic signed [ACCW-1:0]   prod_ext_s;
  logic signed [ACCW:0]     low_s, high_s;
  logic [DATAW:0]           low_sat_s, high_sat_s;

  // Handshake decode: a transfer on a real channel whose phase is 1 launches a MAC pass.
  always_comb begin
    s_ready   = en & ready_r;
    xfer_s    = s_valid & s_ready;
    chan_ok_s = ({1'b0, s_chan} < NCH_LIM);
    if (xfer_s && chan_ok_s) begin
      start_s = phase_r[s_chan];
    end else begin
      start_s = 1'b0;
    end
  end

  // Tap selection, full-precision product and the even/odd butterfly with saturation.
  always_comb begin
    tap_x_s    = dl_r[ch_r][k_r*DATAW +: DATAW];
    tap_c_s    = h0_coef_flat[k_r*COEFW +: COEFW];
    prod_s     = PRODW'(tap_x_s) * PRODW'(tap_c_s);
    prod_ext_s = {{(ACCW - PRODW){prod_s[PRODW-1]}}, prod_s};
    low_s      = {acc_e_r[ACCW-1], acc_e_r} + {acc_o_r[ACCW-1], acc_o_r};
    high_s     = {acc_e_r[ACCW-1], acc_e_r} - {acc_o_r[ACCW-1], acc_o_r};
    low_sat_s  = sat_fn(low_s);
    high_sat_s = sat_fn(high_s);
  end

  // FSM state register; ready_r mirrors "next state is IDLE" but stays 0 while in reset.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_r <= ST_IDLE;
      ready_r <= 1'b0;
    end else begin
      state_r <= state_nxt_s;
      ready_r <= (state_nxt_s == ST_IDLE);
    end
  end

  // FSM next-state: IDLE -> MAC on a phase-1 transfer, MAC walks all taps, OUT lasts one cycle.
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start_s) state_nxt_s = ST_MAC;
        else         state_nxt_s = ST_IDLE;
      end
      ST_MAC: begin
        if (k_r == K_LAST) state_nxt_s = ST_OUT;
        else               state_nxt_s = ST_MAC;
      end
      ST_OUT:  state_nxt_s = ST_IDLE;
      default: state_nxt_s = ST_IDLE;
    endcase
  end

  // Per-channel delay line shift and phase toggle; out-of-range channels are dropped.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < NCH; i++) dl_r[i] <= '0;
      phase_r <= '0;
    end else if (xfer_s && chan_ok_s) begin
      dl_r[s_chan]    <= {dl_r[s_chan][(NTAPS-1)*DATAW-1:0], s_data};
      phase_r[s_chan] <= ~phase_r[s_chan];
    end
  end

  // Serial MAC: even taps accumulate into E, odd taps into O, one tap per cycle.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ch_r    <= '0;
      k_r     <= '0;
      acc_e_r <= '0;
      acc_o_r <= '0;
    end else if (start_s) begin
      ch_r    <= s_chan;
      k_r     <= '0;
      acc_e_r <= '0;
      acc_o_r <= '0;
    end else if (state_r == ST_MAC) begin
      if (k_r[0]) acc_o_r <= acc_o_r + prod_ext_s;
      else        acc_e_r <= acc_e_r + prod_ext_s;
      k_r <= k_r + KW'(1);
    end
  end

  // Output register: capture the pair in OUT and pulse m_valid; values hold between pulses.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      m_valid_r <= 1'b0;
      m_sat_r   <= 1'b0;
      m_chan_r  <= '0;
      m_low_r   <= '0;
      m_high_r  <= '0;
    end else begin
      m_valid_r <= (state_r == ST_OUT);
      if (state_r == ST_OUT) begin
        m_chan_r <= ch_r;
        m_low_r  <= low_sat_s[DATAW-1:0];
        m_high_r <= high_sat_s[DATAW-1:0];
        m_sat_r  <= low_sat_s[DATAW] | high_sat_s[DATAW];
      end
    end
  end

  assign m_valid = m_valid_r;
  assign m_sat   = m_sat_r;
  assign m_chan  = m_chan_r;
  assign m_low   = m_low_r;
  assign m_high  = m_high_r;

endmodule

// File: tb/tb_qmf_analysis_tdm.sv
// Self-checking bench for qmf_analysis_tdm: random stimulus against a direct
// convolution model (low = sum h0*x, high = sum (-1)^k h0*x).
module tb_qmf_analysis_tdm;
  localparam int DATAW = 16, COEFW = 16, NTAPS = 8, NCH = 3, CHW = 2, OUT_SHIFT = 15;

  typedef struct { int ch; int lo; int hi; int sat; int cyc; } res_t;

  logic clk = 1'b0, rstn = 1'b1, en = 1'b1, s_valid = 1'b0;
  logic s_ready, m_valid, m_sat;
  logic [CHW-1:0] s_chan = '0, m_chan;
  logic [DATAW-1:0] s_data = '0, m_low, m_high;
  logic [NTAPS*COEFW-1:0] h0_coef_flat;

  res_t obs_q[$];
  res_t exp_q[$];
  int n_vec = 0, n_bad = 0, cyc = 0;
  int coef[NTAPS];
  int hist[NCH][NTAPS];
  bit ph[NCH];

  qmf_analysis_tdm #(.DATAW(DATAW), .COEFW(COEFW), .NTAPS(NTAPS), .NCH(NCH), .OUT_SHIFT(OUT_SHIFT)) dut (
    .clk(clk), .rstn(rstn), .en(en), .s_valid(s_valid), .s_ready(s_ready), .s_chan(s_chan),
    .s_data(s_data), .h0_coef_flat(h0_coef_flat), .m_valid(m_valid), .m_chan(m_chan),
    .m_low(m_low), .m_high(m_high), .m_sat(m_sat));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always_comb begin
    h0_coef_flat = '0;
    for (int k = 0; k < NTAPS; k++) h0_coef_flat[k*COEFW +: COEFW] = COEFW'(coef[k]);
  end

  always @(negedge clk) begin
    if (m_valid === 1'b1)
      obs_q.push_back('{int'(m_chan), int'($signed(m_low)), int'($signed(m_high)), int'(m_sat), cyc});
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not finish, required finish");
    $fatal(1);
  end

  function automatic int rnd16();
    return int'($urandom_range(0, 65535)) - 32768;
  endfunction

  function automatic int clamp(longint v);
    if (v > 32767) return 32767;
    if (v < -32768) return -32768;
    return int'(v);
  endfunction

  function automatic void model_reset();
    for (int c = 0; c < NCH; c++) begin
      ph[c] = 1'b0;
      for (int k = 0; k < NTAPS; k++) hist[c][k] = 0;
    end
    exp_q.delete();
  endfunction

  // Direct convolution of the full history with h0 and its modulated mirror.
  function automatic void model_xfer(int ch, int d);
    longint lo, hi, p;
    if (ch >= NCH) return;
    for (int k = NTAPS - 1; k > 0; k--) hist[ch][k] = hist[ch][k-1];
    hist[ch][0] = d;
    if (ph[ch]) begin
      lo = 0; hi = 0;
      for (int k = 0; k < NTAPS; k++) begin
        p = longint'(coef[k]) * longint'(hist[ch][k]);
        lo += p;
        hi += (k % 2 == 0) ? p : -p;
      end
      lo = lo >>> OUT_SHIFT;
      hi = hi >>> OUT_SHIFT;
      exp_q.push_back('{ch, clamp(lo), clamp(hi), (longint'(clamp(lo)) != lo || longint'(clamp(hi)) != hi) ? 1 : 0, 0});
    end
    ph[ch] = ~ph[ch];
  endfunction

  function automatic void rand_coefs();
    for (int k = 0; k < NTAPS; k++) coef[k] = rnd16();
  endfunction

  // Present one sample, wait (bounded) for s_ready, complete the transfer.
  task automatic send(input int ch, input int d);
    int waited = 0;
    s_valid = 1'b1; s_chan = CHW'(ch); s_data = DATAW'(d);
    while (s_ready !== 1'b1 && waited < 100) begin
      @(posedge clk); #1; waited++;
    end
    if (waited >= 100) begin
      n_vec++; n_bad++;
      $display("FAIL send_timeout: s_ready=%b after %0d cycles, required 1", s_ready, waited);
      s_valid = 1'b0;
      return;
    end
    @(posedge clk); #1;
    model_xfer(ch, d);
    s_valid = 1'b0;
  endtask

  task automatic do_reset();
    s_valid = 1'b0; en = 1'b1; rstn = 1'b0; model_reset();
    repeat (3) @(posedge clk); #1;
    rstn = 1'b1;
    @(posedge clk); #1;
    obs_q.delete(); exp_q.delete();
  endtask

  task automatic drain(output bit ok);
    int w = 0;
    while (obs_q.size() < exp_q.size() && w < 300) begin
      @(posedge clk); #1; w++;
    end
    repeat (NTAPS + 4) @(posedge clk); #1;
    ok = (w < 300);
  endtask

  task automatic test_reset();
    bit ok;
    en = 1'b1; s_valid = 1'b0;
    #1 rstn = 1'b0; model_reset();
    repeat (3) @(posedge clk); #1;
    n_vec++;
    if ({s_ready, m_valid, m_sat, m_chan, m_low, m_high} !== '0) begin
      n_bad++; $display("FAIL reset_outputs: got %b, required all 0", {s_ready, m_valid, m_sat, m_chan, m_low, m_high});
    end
    rstn = 1'b1; #1;
    n_vec++;
    if (s_ready !== 1'b0) begin n_bad++; $display("FAIL reset_ready_release: got %b, required 0", s_ready); end
    @(posedge clk); #1;
    n_vec++;
    if (s_ready !== 1'b1) begin n_bad++; $display("FAIL reset_ready_after: got %b, required 1", s_ready); end
    rand_coefs(); obs_q.delete();
    send(0, rnd16()); send(0, rnd16());
    repeat (3) @(posedge clk); #1;
    rstn = 1'b0; model_reset();
    repeat (5) @(posedge clk); #1;
    n_vec++;
    if ({s_ready, m_valid, m_sat, m_chan, m_low, m_high} !== '0) begin
      n_bad++; $display("FAIL reset_midmac_outputs: got %b, required all 0", {s_ready, m_valid, m_sat, m_chan, m_low, m_high});
    end
    rstn = 1'b1;
    @(posedge clk); #1;
    n_vec++;
    if (s_ready !== 1'b1) begin n_bad++; $display("FAIL reset_midmac_ready: got %b, required 1", s_ready); end
    repeat (NTAPS + 4) @(posedge clk); #1;
    n_vec++;
    if (obs_q.size() != 0) begin n_bad++; $display("FAIL reset_abort: got %0d m_valid pulses, required 0", obs_q.size()); end
    send(0, rnd16()); send(0, rnd16());
    drain(ok);
    n_vec++;
    if (!ok || obs_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL reset_next_count: got %0d outputs, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (obs_q[i].ch != exp_q[i].ch || obs_q[i].lo != exp_q[i].lo || obs_q[i].hi != exp_q[i].hi || obs_q[i].sat != exp_q[i].sat) begin
        n_bad++; $display("FAIL reset_next_out[%0d]: got ch=%0d lo=%0d hi=%0d sat=%0d, required ch=%0d lo=%0d hi=%0d sat=%0d", i,
          obs_q[i].ch, obs_q[i].lo, obs_q[i].hi, obs_q[i].sat, exp_q[i].ch, exp_q[i].lo, exp_q[i].hi, exp_q[i].sat);
      end
    end
  endtask

  task automatic test_impulse();
    bit ok;
    int lo_c[2], hi_c[2];
    lo_c = '{-2315, 16055}; hi_c = '{2314, -16056};
    do_reset();
    coef = '{308, -2315, 2275, 16056, 16056, 2275, -2315, 308};
    send(0, 32767); send(0, 0); send(0, 0); send(0, 0);
    drain(ok);
    n_vec++;
    if (!ok || obs_q.size() != 2) begin n_bad++; $display("FAIL impulse_count: got %0d outputs, required 2", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < 2; i++) begin
      n_vec++;
      if (obs_q[i].ch != 0 || obs_q[i].lo != lo_c[i] || obs_q[i].hi != hi_c[i] || obs_q[i].sat != 0) begin
        n_bad++; $display("FAIL impulse_out[%0d]: got ch=%0d lo=%0d hi=%0d sat=%0d, required ch=0 lo=%0d hi=%0d sat=0", i,
          obs_q[i].ch, obs_q[i].lo, obs_q[i].hi, obs_q[i].sat, lo_c[i], hi_c[i]);
      end
    end
  endtask

  task automatic test_interleave();
    bit ok;
    int lo_c[2], hi_c[2];
    lo_c = '{-2315, 16055}; hi_c = '{2314, -16056};
    do_reset();
    coef = '{308, -2315, 2275, 16056, 16056, 2275, -2315, 308};
    for (int i = 0; i < 4; i++) begin
      send(0, (i == 0) ? 32767 : 0);
      send(1, 0);
    end
    drain(ok);
    n_vec++;
    if (!ok || obs_q.size() != 4) begin n_bad++; $display("FAIL interleave_count: got %0d outputs, required 4", obs_q.size()); end
    for (int i = 0; i < obs_q.size() && i < 4; i++) begin
      n_vec++;
      if (obs_q[i].ch != (i % 2) || obs_q[i].sat != 0 ||
          obs_q[i].lo != ((i % 2 == 0) ? lo_c[i/2] : 0) || obs_q[i].hi != ((i % 2 == 0) ? hi_c[i/2] : 0)) begin
        n_bad++; $display("FAIL interleave_out[%0d]: got ch=%0d lo=%0d hi=%0d sat=%0d, required ch=%0d lo=%0d hi=%0d sat=0", i,
          obs_q[i].ch, obs_q[i].lo, obs_q[i].hi, obs_q[i].sat, i % 2,
          (i % 2 == 0) ? lo_c[i/2] : 0, (i % 2 == 0) ? hi_c[i/2] : 0);
      end
    end
  endtask

  task automatic test_saturation();
    bit ok;
    do_reset();
    for (int k = 0; k < NTAPS; k++) coef[k] = 32767;
    repeat (NTAPS) send(0, -32768);
    drain(ok);
    n_vec++;
    if (!ok || obs_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL sat_count: got %0d outputs, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (obs_q[i].ch != exp_q[i].ch || obs_q[i].lo != exp_q[i].lo || obs_q[i].hi != exp_q[i].hi || obs_q[i].sat != exp_q[i].sat) begin
        n_bad++; $display("FAIL sat_out[%0d]: got ch=%0d lo=%0d hi=%0d sat=%0d, required ch=%0d lo=%0d hi=%0d sat=%0d", i,
          obs_q[i].ch, obs_q[i].lo, obs_q[i].hi, obs_q[i].sat, exp_q[i].ch, exp_q[i].lo, exp_q[i].hi, exp_q[i].sat);
      end
    end
    n_vec++;
    if (obs_q.size() < 4) begin
      n_bad++; $display("FAIL sat_full: got %0d outputs, required 4", obs_q.size());
    end else if (obs_q[3].lo != -32768 || obs_q[3].hi != 0 || obs_q[3].sat != 1) begin
      n_bad++; $display("FAIL sat_full: got lo=%0d hi=%0d sat=%0d, required lo=-32768 hi=0 sat=1", obs_q[3].lo, obs_q[3].hi, obs_q[3].sat);
    end
  endtask

  task automatic test_throughput();
    bit ok, r, exp_r;
    int d;
    int a_q[$], log_c[$];
    bit log_r[$];
    do_reset();
    rand_coefs();
    d = rnd16(); s_chan = '0; s_data = DATAW'(d); s_valid = 1'b1;
    for (int c = 0; c < 70; c++) begin
      r = s_ready;
      log_c.push_back(cyc); log_r.push_back(r);
      @(posedge clk); #1;
      if (r) begin
        model_xfer(0, d);
        if (!ph[0]) a_q.push_back(cyc);
        d = rnd16(); s_data = DATAW'(d);
      end
    end
    s_valid = 1'b0;
    drain(ok);
    n_vec++;
    if (!ok || obs_q.size() != exp_q.size() || a_q.size() < 4) begin
      n_bad++; $display("FAIL tput_count: got %0d outputs / %0d launches, required %0d / at least 4", obs_q.size(), a_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size() && i < a_q.size(); i++) begin
      n_vec++;
      if (obs_q[i].lo != exp_q[i].lo || obs_q[i].hi != exp_q[i].hi || obs_q[i].sat != exp_q[i].sat || obs_q[i].cyc != a_q[i] + NTAPS + 1) begin
        n_bad++; $display("FAIL tput_out[%0d]: got lo=%0d hi=%0d sat=%0d at edge %0d, required lo=%0d hi=%0d sat=%0d at edge %0d", i,
          obs_q[i].lo, obs_q[i].hi, obs_q[i].sat, obs_q[i].cyc, exp_q[i].lo, exp_q[i].hi, exp_q[i].sat, a_q[i] + NTAPS + 1);
      end
      if (i > 0) begin
        n_vec++;
        if (obs_q[i].cyc - obs_q[i-1].cyc != NTAPS + 3) begin
          n_bad++; $display("FAIL tput_period[%0d]: got %0d cycles, required %0d", i, obs_q[i].cyc - obs_q[i-1].cyc, NTAPS + 3);
        end
      end
    end
    if (a_q.size() > 0) begin
      for (int i = 0; i < log_c.size(); i++) begin
        if (log_c[i] >= a_q[0]) begin
          exp_r = (((log_c[i] - a_q[0]) % (NTAPS + 3)) >= NTAPS + 1);
          n_vec++;
          if (log_r[i] != exp_r) begin
            n_bad++; $display("FAIL tput_ready@%0d: got %b, required %b", log_c[i], log_r[i], exp_r);
          end
        end
      end
    end
  endtask

  task automatic test_en_invalid();
    bit ok;
    int a;
    do_reset();
    rand_coefs();
    send(0, rnd16()); send(0, rnd16());
    a = cyc;
    @(posedge clk); #1;
    en = 1'b0;
    for (int c = 0; c < 16; c++) begin
      n_vec++;
      if (s_ready !== 1'b0) begin n_bad++; $display("FAIL en_block@%0d: got s_ready=%b, required 0", cyc, s_ready); end
      @(posedge clk); #1;
    end
    n_vec++;
    if (obs_q.size() != 1 || exp_q.size() != 1) begin
      n_bad++; $display("FAIL en_deliver_count: got %0d outputs, required 1", obs_q.size());
    end else if (obs_q[0].cyc != a + NTAPS + 1 || obs_q[0].lo != exp_q[0].lo || obs_q[0].hi != exp_q[0].hi) begin
      n_bad++; $display("FAIL en_deliver: got lo=%0d hi=%0d at edge %0d, required lo=%0d hi=%0d at edge %0d",
        obs_q[0].lo, obs_q[0].hi, obs_q[0].cyc, exp_q[0].lo, exp_q[0].hi, a + NTAPS + 1);
    end
    en = 1'b1; #1;
    n_vec++;
    if (s_ready !== 1'b1) begin n_bad++; $display("FAIL en_return: got s_ready=%b, required 1", s_ready); end
    send(NCH, rnd16());
    n_vec++;
    if (s_ready !== 1'b1) begin n_bad++; $display("FAIL invalid_ready: got s_ready=%b, required 1", s_ready); end
    send(NCH, rnd16());
    send(0, rnd16()); send(1, rnd16()); send(NCH, rnd16()); send(0, rnd16()); send(1, rnd16());
    drain(ok);
    n_vec++;
    if (!ok || obs_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL invalid_count: got %0d outputs, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (obs_q[i].ch != exp_q[i].ch || obs_q[i].lo != exp_q[i].lo || obs_q[i].hi != exp_q[i].hi || obs_q[i].sat != exp_q[i].sat) begin
        n_bad++; $display("FAIL invalid_out[%0d]: got ch=%0d lo=%0d hi=%0d sat=%0d, required ch=%0d lo=%0d hi=%0d sat=%0d", i,
          obs_q[i].ch, obs_q[i].lo, obs_q[i].hi, obs_q[i].sat, exp_q[i].ch, exp_q[i].lo, exp_q[i].hi, exp_q[i].sat);
      end
    end
  endtask

  task automatic test_random();
    bit ok;
    do_reset();
    rand_coefs();
    for (int n = 0; n < 60; n++) begin
      send(int'($urandom_range(0, NCH)), rnd16());
      repeat ($urandom_range(0, 2)) begin @(posedge clk); #1; end
    end
    drain(ok);
    n_vec++;
    if (!ok || obs_q.size() != exp_q.size()) begin
      n_bad++; $display("FAIL random_count: got %0d outputs, required %0d", obs_q.size(), exp_q.size());
    end
    for (int i = 0; i < obs_q.size() && i < exp_q.size(); i++) begin
      n_vec++;
      if (obs_q[i].ch != exp_q[i].ch || obs_q[i].lo != exp_q[i].lo || obs_q[i].hi != exp_q[i].hi || obs_q[i].sat != exp_q[i].sat) begin
        n_bad++; $display("FAIL random_out[%0d]: got ch=%0d lo=%0d hi=%0d sat=%0d, required ch=%0d lo=%0d hi=%0d sat=%0d", i,
          obs_q[i].ch, obs_q[i].lo, obs_q[i].hi, obs_q[i].sat, exp_q[i].ch, exp_q[i].lo, exp_q[i].hi, exp_q[i].sat);
      end
    end
  endtask

  initial begin
    for (int k = 0; k < NTAPS; k++) coef[k] = 0;
    test_reset();
    test_impulse();
    test_interleave();
    test_saturation();
    test_throughput();
    test_en_invalid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
